// File: rtl/dart_game_ctrl.sv
// Two-player dart game controller: edge-detects darts, maps hit position to
// points, runs three-dart turns with bust/win handling and registered outputs.
module dart_game_ctrl #(
  parameter int START_SCORE    = 301,
  parameter int DARTS_PER_TURN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dart_come_i,
  input  logic [3:0] dart_position_x_i,
  input  logic [3:0] dart_position_y_i,
  output logic       game_set_o,
  output logic       player_1_done_o,
  output logic       player_2_done_o,
  output logic       player_1_win_o,
  output logic       player_2_win_o,
  output logic [8:0] p1_score_o,
  output logic [8:0] p2_score_o,
  output logic [1:0] dart_cnt_o
);

  localparam logic [1:0] P1_WAIT   = 2'd0;
  localparam logic [1:0] P2_WAIT   = 2'd1;
  localparam logic [1:0] EVAL      = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  localparam logic [8:0] START = 9'(START_SCORE);
  localparam logic [1:0] LAST  = 2'(DARTS_PER_TURN - 1);

  logic [1:0]        state;
  logic              act_p2;
  logic              come_q;
  logic [3:0]        x_q;
  logic [3:0]        y_q;
  logic [8:0]        turn_start;
  logic [3:0]        dx;
  logic [3:0]        dy;
  logic [3:0]        d;
  logic [5:0]        pts;
  logic [8:0]        cur;
  logic signed [9:0] diff;

  always_comb begin
    dx = (x_q >= 4'd7) ? (x_q - 4'd7) : (4'd7 - x_q);
    dy = (y_q >= 4'd7) ? (y_q - 4'd7) : (4'd7 - y_q);
    d  = (dx > dy) ? dx : dy;
  end

  always_comb begin
    pts = 6'd0;
    unique case (1'b1)
      (d == 4'd0):                 pts = 6'd50;
      (d == 4'd1):                 pts = 6'd25;
      (d >= 4'd2 && d <= 4'd3):    pts = 6'd20;
      (d >= 4'd4 && d <= 4'd5):    pts = 6'd10;
      (d >= 4'd6 && d <= 4'd7):    pts = 6'd5;
      default:                     pts = 6'd0;
    endcase
  end

  // Sign bit of diff flags a bust; zero is a win.
  always_comb begin
    cur  = act_p2 ? p2_score_o : p1_score_o;
    diff = $signed({1'b0, cur}) - $signed({4'b0, pts});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= P1_WAIT;
      act_p2          <= 1'b0;
      come_q          <= 1'b1;
      x_q             <= 4'd0;
      y_q             <= 4'd0;
      turn_start      <= START;
      p1_score_o      <= START;
      p2_score_o      <= START;
      dart_cnt_o      <= 2'd0;
      game_set_o      <= 1'b0;
      player_1_done_o <= 1'b0;
      player_2_done_o <= 1'b0;
      player_1_win_o  <= 1'b0;
      player_2_win_o  <= 1'b0;
    end else begin
      come_q          <= dart_come_i;
      player_1_done_o <= 1'b0;
      player_2_done_o <= 1'b0;
      unique case (state)
        P1_WAIT, P2_WAIT: begin
          if (dart_come_i && !come_q) begin
            x_q    <= dart_position_x_i;
            y_q    <= dart_position_y_i;
            act_p2 <= (state == P2_WAIT);
            state  <= EVAL;
          end
        end
        EVAL: begin
          if (diff == 10'sd0) begin
            state      <= GAME_OVER;
            game_set_o <= 1'b1;
            if (act_p2) begin
              p2_score_o     <= 9'd0;
              player_2_win_o <= 1'b1;
            end else begin
              p1_score_o     <= 9'd0;
              player_1_win_o <= 1'b1;
            end
          end else if (diff[9] || dart_cnt_o == LAST) begin
            dart_cnt_o <= 2'd0;
            if (act_p2) begin
              p2_score_o      <= diff[9] ? turn_start : diff[8:0];
              player_2_done_o <= 1'b1;
              turn_start      <= p1_score_o;
              state           <= P1_WAIT;
            end else begin
              p1_score_o      <= diff[9] ? turn_start : diff[8:0];
              player_1_done_o <= 1'b1;
              turn_start      <= p2_score_o;
              state           <= P2_WAIT;
            end
          end else begin
            dart_cnt_o <= dart_cnt_o + 2'd1;
            if (act_p2) begin
              p2_score_o <= diff[8:0];
              state      <= P2_WAIT;
            end else begin
              p1_score_o <= diff[8:0];
              state      <= P1_WAIT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dart_game_ctrl.sv
// Bench for dart_game_ctrl: two instances (301 and 100 start) share stimulus
// and are compared every cycle against a game-rule model, plus directed checks.
module tb_dart_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       come = 1'b0;
  logic [3:0] px = 4'd0;
  logic [3:0] py = 4'd0;

  logic       gs[2];
  logic       d1[2];
  logic       d2[2];
  logic       w1[2];
  logic       w2[2];
  logic [8:0] s1[2];
  logic [8:0] s2[2];
  logic [1:0] dc[2];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;

  always #10 clk = ~clk;

  dart_game_ctrl #(.START_SCORE(301), .DARTS_PER_TURN(3)) dut_a (
    .clk(clk), .reset(rst_n), .dart_come_i(come),
    .dart_position_x_i(px), .dart_position_y_i(py),
    .game_set_o(gs[0]), .player_1_done_o(d1[0]),
    .player_2_done_o(d2[0]), .player_1_win_o(w1[0]),
    .player_2_win_o(w2[0]), .p1_score_o(s1[0]),
    .p2_score_o(s2[0]), .dart_cnt_o(dc[0])
  );

  dart_game_ctrl #(.START_SCORE(100), .DARTS_PER_TURN(3)) dut_b (
    .clk(clk), .reset(rst_n), .dart_come_i(come),
    .dart_position_x_i(px), .dart_position_y_i(py),
    .game_set_o(gs[1]), .player_1_done_o(d1[1]),
    .player_2_done_o(d2[1]), .player_1_win_o(w1[1]),
    .player_2_win_o(w2[1]), .p1_score_o(s1[1]),
    .p2_score_o(s2[1]), .dart_cnt_o(dc[1])
  );

  typedef struct packed {
    int sc1; int sc2; int ts; int cnt; int pts;
    bit p2; bit pend; bit over;
    bit win1; bit win2; bit dn1; bit dn2; bit prev;
  } model_t;

  model_t mdl[2];

  function automatic int pts_of(int x, int y);
    int ax, ay, d;
    ax = (x > 7) ? x - 7 : 7 - x;
    ay = (y > 7) ? y - 7 : 7 - y;
    d  = (ax > ay) ? ax : ay;
    if (d == 0) return 50;
    if (d == 1) return 25;
    if (d <= 3) return 20;
    if (d <= 5) return 10;
    if (d <= 7) return 5;
    return 0;
  endfunction

  function automatic model_t init_m(int s);
    model_t m;
    m = '0;
    m.sc1 = s;
    m.sc2 = s;
    m.ts = s;
    m.prev = 1'b1;
    return m;
  endfunction

  function automatic model_t step(model_t m, bit c, int x, int y);
    model_t n;
    int cur, nv, res;
    bit end_t;
    n = m;
    n.dn1 = 1'b0;
    n.dn2 = 1'b0;
    n.prev = c;
    end_t = 1'b0;
    if (m.over) return n;
    if (m.pend) begin
      n.pend = 1'b0;
      cur = m.p2 ? m.sc2 : m.sc1;
      nv = cur - m.pts;
      if (nv < 0) begin
        res = m.ts;
        end_t = 1'b1;
      end else if (nv == 0) begin
        res = 0;
        n.over = 1'b1;
        if (m.p2) n.win2 = 1'b1;
        else n.win1 = 1'b1;
      end else begin
        res = nv;
        n.cnt = m.cnt + 1;
        end_t = (n.cnt == 3);
      end
      if (m.p2) n.sc2 = res;
      else n.sc1 = res;
      if (end_t) begin
        if (m.p2) n.dn2 = 1'b1;
        else n.dn1 = 1'b1;
        n.cnt = 0;
        n.ts = m.p2 ? n.sc1 : n.sc2;
        n.p2 = !m.p2;
      end
    end else if (c && !m.prev) begin
      n.pend = 1'b1;
      n.pts = pts_of(x, y);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= init_m(301);
      mdl[1] <= init_m(100);
    end else begin
      for (int k = 0; k < 2; k++)
        mdl[k] <= step(mdl[k], come, int'(px), int'(py));
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m_p1_score[%0d]", k), int'(s1[k]), mdl[k].sc1);
      chk($sformatf("m_p2_score[%0d]", k), int'(s2[k]), mdl[k].sc2);
      chk($sformatf("m_game_set[%0d]", k), int'(gs[k]), int'(mdl[k].over));
      chk($sformatf("m_p1_win[%0d]", k), int'(w1[k]), int'(mdl[k].win1));
      chk($sformatf("m_p2_win[%0d]", k), int'(w2[k]), int'(mdl[k].win2));
      chk($sformatf("m_p1_done[%0d]", k), int'(d1[k]), int'(mdl[k].dn1));
      chk($sformatf("m_p2_done[%0d]", k), int'(d2[k]), int'(mdl[k].dn2));
      if (!mdl[k].over)
        chk($sformatf("m_dart_cnt[%0d]", k), int'(dc[k]), mdl[k].cnt);
    end
  end

  always @(posedge clk) begin
    if (d1[1]) done1_cnt <= done1_cnt + 1;
    if (d2[1]) done2_cnt <= done2_cnt + 1;
  end

  // Returns on the negedge where the dart's result and any done pulse show.
  task automatic throw(input int x, input int y);
    @(negedge clk);
    px = 4'(x);
    py = 4'(y);
    come = 1'b1;
    @(negedge clk);
    come = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    come = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    int pts;
  } vec_t;

  vec_t tbl[14];
  int base1, base2;

  initial begin
    tbl[0]  = '{4'd7,  4'd7,  50};
    tbl[1]  = '{4'd8,  4'd6,  25};
    tbl[2]  = '{4'd6,  4'd8,  25};
    tbl[3]  = '{4'd9,  4'd7,  20};
    tbl[4]  = '{4'd4,  4'd10, 20};
    tbl[5]  = '{4'd3,  4'd7,  10};
    tbl[6]  = '{4'd12, 4'd2,  10};
    tbl[7]  = '{4'd2,  4'd9,  10};
    tbl[8]  = '{4'd1,  4'd7,  5};
    tbl[9]  = '{4'd7,  4'd13, 5};
    tbl[10] = '{4'd0,  4'd0,  5};
    tbl[11] = '{4'd15, 4'd15, 0};
    tbl[12] = '{4'd15, 4'd8,  0};
    tbl[13] = '{4'd7,  4'd15, 0};

    // Reset with dart_come_i held high
    #1 rst_n = 1'b0;
    come = 1'b1;
    px = 4'd0;
    py = 4'd0;
    #100 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_p1_score", int'(s1[0]), 301);
    chk("rst_p2_score", int'(s2[0]), 301);
    chk("rst_dart_cnt", int'(dc[0]), 0);
    chk("rst_flags", int'({gs[0], d1[0], d2[0], w1[0], w2[0]}), 0);
    chk("rst_p1_score_b", int'(s1[1]), 100);
    come = 1'b0;
    @(negedge clk);

    // Single bull
    throw(7, 7);
    chk("bull_p1", int'(s1[0]), 251);
    chk("bull_cnt", int'(dc[0]), 1);
    chk("bull_p2", int'(s2[0]), 301);

    // Full turn for player 1
    do_reset();
    throw(7, 7);
    chk("turn_d1", int'(s1[0]), 251);
    throw(8, 8);
    chk("turn_d2", int'(s1[0]), 226);
    throw(0, 0);
    chk("turn_d3", int'(s1[0]), 221);
    chk("turn_done_hi", int'(d1[0]), 1);
    chk("turn_cnt0", int'(dc[0]), 0);
    @(negedge clk);
    chk("turn_done_lo", int'(d1[0]), 0);
    throw(9, 7);
    chk("turn_p2", int'(s2[0]), 281);

    // Bust on the 100-point instance
    do_reset();
    throw(7, 7);
    throw(8, 7);
    chk("bust_p1_25", int'(s1[1]), 25);
    throw(15, 15);
    repeat (3) throw(15, 15);
    chk("bust_p2_miss", int'(s2[1]), 100);
    base1 = done1_cnt;
    throw(7, 7);
    chk("bust_restore", int'(s1[1]), 25);
    chk("bust_done", int'(d1[1]), 1);
    repeat (3) @(negedge clk);
    chk("bust_done_width", done1_cnt - base1, 1);
    throw(9, 7);
    chk("bust_p2_next", int'(s2[1]), 80);

    // Win on the 100-point instance
    do_reset();
    base1 = done1_cnt;
    throw(7, 7);
    throw(7, 7);
    chk("win_score", int'(s1[1]), 0);
    chk("win_flag", int'(w1[1]), 1);
    chk("win_set", int'(gs[1]), 1);
    chk("win_other", int'(w2[1]), 0);
    repeat (5) throw(7, 7);
    chk("win_frozen_p1", int'(s1[1]), 0);
    chk("win_frozen_p2", int'(s2[1]), 100);
    chk("win_no_done", done1_cnt - base1, 0);
    chk("win_held", int'(w1[1]), 1);

    // Extra edge inside EVAL, then a long hold
    do_reset();
    @(negedge clk);
    px = 4'd9;
    py = 4'd7;
    come = 1'b1;
    @(posedge clk);
    #2 come = 1'b0;
    #3 come = 1'b1;
    repeat (50) @(negedge clk);
    come = 1'b0;
    repeat (2) @(negedge clk);
    chk("glitch_a", int'(s1[0]), 281);
    chk("glitch_b", int'(s1[1]), 80);

    // Point map table
    for (int i = 0; i < 14; i++) begin
      do_reset();
      throw(int'(tbl[i].x), int'(tbl[i].y));
      chk($sformatf("map_a[%0d]", i), int'(s1[0]), 301 - tbl[i].pts);
      chk($sformatf("map_b[%0d]", i), int'(s1[1]), 100 - tbl[i].pts);
    end

    // Random play with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      px = 4'($urandom_range(0, 15));
      py = 4'($urandom_range(0, 15));
      come = ($urandom_range(0, 2) == 0);
      if (i % 500 == 499) begin
        #($urandom_range(1, 8)) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
